// File: rtl/aligner_pkg.sv
// -----------------------------------------------------------------------------
// aligner_pkg
// Shared constants and the FSM state type for the exponent aligner.
//   W_EXP     : default exponent width
//   W_SIG     : default significand width (hidden bit included)
//   MAX_SHIFT : shift cap; any larger exponent difference clears the
//               shifted significand completely
//   CNT_W     : shift counter width, wide enough to hold MAX_SHIFT
//   state_t   : aligner FSM states
// -----------------------------------------------------------------------------
package aligner_pkg;

  localparam int W_EXP     = 8;
  localparam int W_SIG     = 24;
  localparam int MAX_SHIFT = 25;
  localparam int CNT_W     = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : aligner_pkg

// File: rtl/exponent_aligner.sv
// -----------------------------------------------------------------------------
// exponent_aligner
// Aligns the significand of the smaller floating-point operand to the larger
// one by shifting it right one bit per cycle, up to MAX_SHIFT positions.
//
// Optional feature macro: ALIGNER_STICKY_EN
//   defined   : sticky collects every bit shifted out of Sig_Min_Sh
//   undefined : sticky is tied to 0 and no sticky register exists
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous, active-low reset
//   start      in   request to align one operand pair
//   A_gt_B     in   Exp_A > Exp_B flag from the external comparator
//   Exp_A/B    in   operand exponents   (W_EXP)
//   Sig_A/B    in   operand significands (W_SIG)
//   busy       out  high in LOAD and SHIFT
//   done       out  one-cycle pulse, outputs valid
//   Exp_Max    out  larger exponent
//   Sig_Max    out  significand of the larger operand, unshifted
//   Sig_Min_Sh out  smaller significand shifted right by the difference
//   sticky     out  OR of the bits shifted out of Sig_Min_Sh
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: start is sampled only in IDLE or DONE; when sampled, all operand
// inputs (including A_gt_B) are captured on that same edge. start seen in LOAD
// or SHIFT is ignored. done pulses for exactly one cycle; the data outputs hold
// from done until the next LOAD, so they may be read any time after done.
// Holding start high through DONE starts the next operation with no IDLE gap.
// -----------------------------------------------------------------------------
module exponent_aligner
  import aligner_pkg::*;
#(
  parameter int W_EXP = aligner_pkg::W_EXP,
  parameter int W_SIG = aligner_pkg::W_SIG
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             A_gt_B,
  input  logic [W_EXP-1:0] Exp_A,
  input  logic [W_EXP-1:0] Exp_B,
  input  logic [W_SIG-1:0] Sig_A,
  input  logic [W_SIG-1:0] Sig_B,
  output logic             busy,
  output logic             done,
  output logic [W_EXP-1:0] Exp_Max,
  output logic [W_SIG-1:0] Sig_Max,
  output logic [W_SIG-1:0] Sig_Min_Sh,
  output logic             sticky,
  output state_t           dbg_state
);

  state_t             state;
  state_t             state_nxt;

  logic               a_gt_b_q;
  logic [W_EXP-1:0]   exp_a_q;
  logic [W_EXP-1:0]   exp_b_q;
  logic [W_SIG-1:0]   sig_a_q;
  logic [W_SIG-1:0]   sig_b_q;

  logic [CNT_W-1:0]   cnt;

  logic               take_start;
  logic [W_EXP-1:0]   exp_max_sel;
  logic [W_EXP-1:0]   exp_min_sel;
  logic [W_SIG-1:0]   sig_max_sel;
  logic [W_SIG-1:0]   sig_min_sel;
  logic [W_EXP-1:0]   exp_diff;
  logic [CNT_W-1:0]   shift_amt;

  assign take_start = start && ((state == IDLE) || (state == DONE));

  // Equal exponents fall through to B as the larger operand. A wrong A_gt_B
  // makes exp_diff wrap to a large value, which the cap below bounds, so the
  // FSM always finishes within MAX_SHIFT+1 cycles.
  assign exp_max_sel = a_gt_b_q ? exp_a_q : exp_b_q;
  assign exp_min_sel = a_gt_b_q ? exp_b_q : exp_a_q;
  assign sig_max_sel = a_gt_b_q ? sig_a_q : sig_b_q;
  assign sig_min_sel = a_gt_b_q ? sig_b_q : sig_a_q;
  assign exp_diff    = exp_max_sel - exp_min_sel;
  assign shift_amt   = (exp_diff > W_EXP'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT)
                                                      : CNT_W'(exp_diff);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = (shift_amt != '0) ? SHIFT : DONE;
      // cnt is decremented on this same edge, so 1 here means it reaches 0.
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == LOAD) || (state == SHIFT);
  assign done      = (state == DONE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_gt_b_q <= 1'b0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      sig_a_q  <= '0;
      sig_b_q  <= '0;
    end else if (take_start) begin
      a_gt_b_q <= A_gt_B;
      exp_a_q  <= Exp_A;
      exp_b_q  <= Exp_B;
      sig_a_q  <= Sig_A;
      sig_b_q  <= Sig_B;
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Exp_Max    <= '0;
      Sig_Max    <= '0;
      Sig_Min_Sh <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        LOAD: begin
          Exp_Max    <= exp_max_sel;
          Sig_Max    <= sig_max_sel;
          Sig_Min_Sh <= sig_min_sel;
          cnt        <= shift_amt;
        end
        SHIFT: begin
          Sig_Min_Sh <= Sig_Min_Sh >> 1;
          cnt        <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ALIGNER_STICKY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sticky <= 1'b0;
    end else begin
      case (state)
        LOAD:    sticky <= 1'b0;
        SHIFT:   sticky <= sticky | Sig_Min_Sh[0];
        default: ;
      endcase
    end
  end
`else
  assign sticky = 1'b0;
`endif

endmodule : exponent_aligner
